// File: rtl/wb_pkg.sv
// Shared writeback-queue definitions: default widths, depth and the queue entry layout.
package wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending writeback entries for one decode read port.
module wb_fwd_match #(
    parameter int DEPTH = wb_pkg::DEPTH_DEF,
    parameter int XLEN  = wb_pkg::XLEN
) (
    input  logic [DEPTH-1:0]                ent_vld,
    input  logic [wb_pkg::REG_ADDR_W-1:0]   ent_rd   [DEPTH],
    input  logic [XLEN-1:0]                 ent_data [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]        rptr,
    input  logic [wb_pkg::REG_ADDR_W-1:0]   rs,
    output logic                            match_hit,
    output logic [XLEN-1:0]                 match_data
);
    import wb_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    // Walk oldest to youngest from the head so the last match seen is the youngest.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rptr + PW'(i);
            if (ent_vld[idx] && (ent_rd[idx] == rs) && (rs != '0)) begin
                match_hit  = 1'b1;
                match_data = ent_data[idx];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue merging LSU and ALU results into one register-file write port,
// with a bypass of pending values to decode.
module wb_queue #(
    parameter int DEPTH = wb_pkg::DEPTH_DEF,
    parameter int XLEN  = wb_pkg::XLEN
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            lsu_valid,
    output logic                            lsu_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0]   lsu_rd,
    input  logic [XLEN-1:0]                 lsu_data,
    input  logic                            alu_valid,
    output logic                            alu_ready,
    input  logic [wb_pkg::REG_ADDR_W-1:0]   alu_rd,
    input  logic [XLEN-1:0]                 alu_data,
    output logic                            rf_we,
    output logic [wb_pkg::REG_ADDR_W-1:0]   rf_rd,
    output logic [XLEN-1:0]                 rf_wdata,
    input  logic [wb_pkg::REG_ADDR_W-1:0]   rs1,
    input  logic [wb_pkg::REG_ADDR_W-1:0]   rs2,
    output logic                            fwd_hit1,
    output logic [XLEN-1:0]                 fwd_data1,
    output logic                            fwd_hit2,
    output logic [XLEN-1:0]                 fwd_data2,
    output logic [$clog2(DEPTH):0]          count,
    output logic                            full,
    output logic                            empty
);
    import wb_pkg::*;

    localparam int            PW      = $clog2(DEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [PW-1:0]         rptr_q;
    logic [PW-1:0]         wptr_q;
    logic [CW-1:0]         count_q;
    logic [DEPTH-1:0]      vld_q;
    logic [DEPTH-1:0]      vld_d;
    logic [REG_ADDR_W-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]       data_mem [DEPTH];

    logic [CW-1:0] free_w;
    logic          store_l;
    logic          store_a;
    logic          pop;
    logic [1:0]    nstore;
    logic [PW-1:0] slot_a;

    // Free space comes from registered count only, so a same-cycle pop never frees a slot.
    assign free_w    = DEPTH_C - count_q;
    assign lsu_ready = (free_w >= CW'(1));
    assign alu_ready = lsu_valid ? (free_w >= CW'(2)) : (free_w >= CW'(1));

    // x0 writes complete the handshake but are dropped.
    assign store_l = lsu_valid && lsu_ready && (lsu_rd != '0);
    assign store_a = alu_valid && alu_ready && (alu_rd != '0);
    assign nstore  = {1'b0, store_l} + {1'b0, store_a};
    assign slot_a  = store_l ? (wptr_q + PW'(1)) : wptr_q;
    assign pop     = (count_q != '0);

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == DEPTH_C);
    assign rf_we    = !empty;
    assign rf_rd    = rd_mem[rptr_q];
    assign rf_wdata = data_mem[rptr_q];

    always_comb begin
        vld_d = vld_q;
        if (pop)     vld_d[rptr_q] = 1'b0;
        if (store_l) vld_d[wptr_q] = 1'b1;
        if (store_a) vld_d[slot_a] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            wptr_q  <= wptr_q + PW'(nstore);
            count_q <= count_q + CW'(nstore) - CW'(pop);
            if (pop) rptr_q <= rptr_q + PW'(1);
        end
    end

    // Entry payload carries no reset; the valid bits above qualify it.
    always_ff @(posedge clk) begin
        if (store_l) begin
            rd_mem[wptr_q]   <= lsu_rd;
            data_mem[wptr_q] <= lsu_data;
        end
        if (store_a) begin
            rd_mem[slot_a]   <= alu_rd;
            data_mem[slot_a] <= alu_data;
        end
    end

    wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd1 (
        .ent_vld    (vld_q),
        .ent_rd     (rd_mem),
        .ent_data   (data_mem),
        .rptr       (rptr_q),
        .rs         (rs1),
        .match_hit  (fwd_hit1),
        .match_data (fwd_data1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd2 (
        .ent_vld    (vld_q),
        .ent_rd     (rd_mem),
        .ent_data   (data_mem),
        .rptr       (rptr_q),
        .rs         (rs2),
        .match_hit  (fwd_hit2),
        .match_data (fwd_data2)
    );

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue (DEPTH=4, XLEN=32) with immediate-assertion checks.
module tb_wb_queue;

    logic        clk;
    logic        rst;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic [4:0]  rs1, rs2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [2:0]  count;
    logic        full, empty;

    int passed = 0;
    int total  = 0;

    wb_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .rf_we     (rf_we),
        .rf_rd     (rf_rd),
        .rf_wdata  (rf_wdata),
        .rs1       (rs1),
        .rs2       (rs2),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    endtask

    task automatic push_l(input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = 1'b1; lsu_rd = rd; lsu_data = d;
    endtask

    task automatic push_a(input logic [4:0] rd, input logic [31:0] d);
        alu_valid = 1'b1; alu_rd = rd; alu_data = d;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs1 = '0; rs2 = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_lsu_ready", lsu_ready, 1);
        chk("rst_fwd_hit1", fwd_hit1, 0);
        lsu_valid = 1'b1; #1;
        chk("rst_alu_ready", alu_ready, 1);
        idle();
        rst = 1'b0;

        // Single ALU write
        @(negedge clk);
        push_a(5, 32'hDEADBEEF); rs1 = 5; #1;
        chk("single_alu_ready", alu_ready, 1);
        chk("single_fwd_not_yet", fwd_hit1, 0);
        @(negedge clk); idle(); #1;
        chk("single_rf_we", rf_we, 1);
        chk("single_rf_rd", rf_rd, 5);
        chk("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
        chk("single_count", count, 1);
        chk("single_fwd_hit", fwd_hit1, 1);
        chk("single_fwd_data", fwd_data1, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("single_empty_after", empty, 1);
        chk("single_rf_we_after", rf_we, 0);

        // Dual accept, same rd: LSU older, ALU younger
        push_l(3, 32'h11); push_a(3, 32'h22); rs1 = 3; #1;
        chk("dual_lsu_ready", lsu_ready, 1);
        chk("dual_alu_ready", alu_ready, 1);
        @(negedge clk); idle(); #1;
        chk("dual_count", count, 2);
        chk("dual_first_data", rf_wdata, 32'h11);
        chk("dual_fwd_hit", fwd_hit1, 1);
        chk("dual_fwd_youngest", fwd_data1, 32'h22);
        @(negedge clk); #1;
        chk("dual_count2", count, 1);
        chk("dual_second_data", rf_wdata, 32'h22);
        chk("dual_fwd_youngest2", fwd_data1, 32'h22);
        @(negedge clk); #1;
        chk("dual_empty", empty, 1);

        // Fill to count=3 and probe the ready split
        push_l(1, 32'hA1); push_a(2, 32'hA2);
        @(negedge clk); #1;
        chk("fill_a_count", count, 2);
        chk("fill_a_alu_ready", alu_ready, 1);
        push_l(3, 32'hB1); push_a(4, 32'hB2);
        @(negedge clk); idle(); #1;
        chk("fill_b_count", count, 3);
        chk("fill_alu_ready_alone", alu_ready, 1);
        push_l(6, 32'hC1); push_a(7, 32'hC2); #1;
        chk("fill_lsu_ready", lsu_ready, 1);
        chk("fill_alu_ready", alu_ready, 0);
        @(negedge clk); idle(); rs1 = 6; rs2 = 7; #1;
        chk("fill_c_count", count, 3);
        chk("fill_full", full, 0);
        chk("fill_head", rf_wdata, 32'hB1);
        chk("fill_fwd1_hit", fwd_hit1, 1);
        chk("fill_fwd1_data", fwd_data1, 32'hC1);
        chk("fill_fwd2_hit", fwd_hit2, 0);
        chk("fill_fwd2_data", fwd_data2, 0);
        @(negedge clk); #1;
        chk("fill_drain1", rf_wdata, 32'hB2);
        chk("fill_drain1_rd", rf_rd, 4);
        @(negedge clk); #1;
        chk("fill_drain2", rf_wdata, 32'hC1);
        @(negedge clk); #1;
        chk("fill_drained", empty, 1);

        // Write to x0 is accepted but dropped
        push_a(0, 32'h55); rs1 = 0; #1;
        chk("x0_alu_ready", alu_ready, 1);
        chk("x0_fwd_hit", fwd_hit1, 0);
        @(negedge clk); idle(); #1;
        chk("x0_count", count, 0);
        chk("x0_rf_we", rf_we, 0);

        // Continuous stream across pointer wrap
        for (int i = 1; i <= 10; i++) begin
            push_a(5'(i), 32'(i * 32'h100));
            @(negedge clk); #1;
            chk("wrap_rf_we", rf_we, 1);
            chk("wrap_rf_rd", rf_rd, 5'(i));
            chk("wrap_rf_wdata", rf_wdata, 32'(i * 32'h100));
            chk("wrap_count_bound", (count <= 3'd4), 1);
        end
        idle();
        @(negedge clk); #1;
        chk("wrap_empty", empty, 1);

        // Reset while holding pending entries
        push_l(1, 32'h31); push_a(2, 32'h32);
        @(negedge clk);
        push_l(3, 32'h33); push_a(4, 32'h34);
        @(negedge clk); idle(); rs1 = 4; rs2 = 9; #1;
        chk("mid_count", count, 3);
        chk("mid_fwd_hit", fwd_hit1, 1);
        push_l(9, 32'h99); push_a(9, 32'h98);
        rst = 1'b1; #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_rf_we", rf_we, 0);
        chk("mid_rst_fwd_hit", fwd_hit1, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_alu_ready", alu_ready, 1);
        @(negedge clk); idle(); rst = 1'b0; #1;
        chk("post_rst_count", count, 0);
        chk("post_rst_rf_we", rf_we, 0);
        chk("post_rst_fwd2", fwd_hit2, 0);
        @(negedge clk); #1;
        chk("post_rst_rf_we2", rf_we, 0);
        chk("post_rst_empty", empty, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
